// File: rtl/alert_framer.sv
// alert_framer: debounces a 2-bit alert level and sends a serial status frame.
// A frame is sent when the debounced level changes or a heartbeat interval elapses.
// Line is idle high; MSB first; every bit is held for BIT_DIV cycles.
// Frame: 8'hA5, NODE_ID, level, seq, temp, pres (32 bits).
// Optional macro ALERT_FRAMER_CKSUM_EN appends a checksum byte (40 bits).
// The checksum byte is {NODE_ID,level,seq} ^ temp ^ pres.
module alert_framer #(
    parameter logic [3:0]  NODE_ID    = 4'h1,
    parameter int unsigned BIT_DIV    = 16,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned HEARTBEAT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] alert_level,
    input  logic [7:0] temp,
    input  logic [7:0] pres,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       frame_done,
    output logic [1:0] level_q
);

`ifdef ALERT_FRAMER_CKSUM_EN
    localparam int unsigned FRAME_LEN = 40;
`else
    localparam int unsigned FRAME_LEN = 32;
`endif

    localparam logic [7:0]  DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [7:0]  STABLE8  = 8'(STABLE_CNT);
    localparam logic [15:0] HB_LAST  = 16'(HEARTBEAT - 1);
    localparam logic [5:0]  BIT_LAST = 6'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             samp;
    logic [7:0]             stab_cnt, run_nxt;
    logic [1:0]             last_sent;
    logic [1:0]             seq;
    logic [7:0]             div_cnt;
    logic [5:0]             bit_cnt;
    logic [15:0]            hb_cnt;
    logic [FRAME_LEN-1:0]   frame_sr;
    logic [FRAME_LEN-1:0]   frame_word;
    logic                   trigger, start, bit_end, last_bit;

    // Length of the current run of identical samples, saturating at STABLE_CNT.
    always_comb begin
        run_nxt = 8'd1;
        if (alert_level == samp) begin
            if (stab_cnt >= STABLE8) run_nxt = STABLE8;
            else                     run_nxt = stab_cnt + 8'd1;
        end
    end

    // Debouncer: accept a level once it has been seen on STABLE_CNT edges in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp     <= '0;
            stab_cnt <= '0;
            level_q  <= '0;
        end else begin
            samp     <= alert_level;
            stab_cnt <= run_nxt;
            if (run_nxt >= STABLE8) level_q <= alert_level;
        end
    end

    assign trigger  = (level_q != last_sent) || (hb_cnt == HB_LAST);
    assign start    = (state == IDLE) && enable && trigger;
    assign bit_end  = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

`ifdef ALERT_FRAMER_CKSUM_EN
    assign frame_word = {8'hA5, NODE_ID, level_q, seq, temp, pres,
                         {NODE_ID, level_q, seq} ^ temp ^ pres};
`else
    assign frame_word = {8'hA5, NODE_ID, level_q, seq, temp, pres};
`endif

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (bit_end && last_bit) state_nxt = GAP;
            GAP:     if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, bit timing, heartbeat and frame snapshot/shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            hb_cnt    <= '0;
            seq       <= '0;
            last_sent <= '0;
            frame_sr  <= '0;
        end else begin
            state <= state_nxt;

            if (start || !enable)  hb_cnt <= '0;
            else if (state == IDLE) hb_cnt <= hb_cnt + 16'd1;

            if (state == IDLE || bit_end) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 8'd1;

            if (start) begin
                frame_sr  <= frame_word;
                last_sent <= level_q;
                seq       <= seq + 2'd1;
                bit_cnt   <= '0;
            end else if (state == SEND && bit_end) begin
                frame_sr <= {frame_sr[FRAME_LEN-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 6'd1;
            end
        end
    end

    assign tx_active  = (state == SEND);
    assign tx_bit     = tx_active ? frame_sr[FRAME_LEN-1] : 1'b1;
    assign frame_done = (state == GAP) && (div_cnt == '0);

endmodule

// File: tb/tb_alert_framer.sv
// tb_alert_framer: directed scenarios plus randomized stimulus for alert_framer,
// checked every cycle against a frame-timeline reference model.
module tb_alert_framer;

    localparam int         BD   = 4;
    localparam int         SC   = 4;
    localparam int         HB   = 20;
    localparam logic [3:0] NODE = 4'h1;
`ifdef ALERT_FRAMER_CKSUM_EN
    localparam int FL = 40;
`else
    localparam int FL = 32;
`endif
    localparam int XB = FL - 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] alert_level = 2'b00;
    logic [7:0] temp = 8'h00;
    logic [7:0] pres = 8'h00;
    logic       tx_bit, tx_active, frame_done;
    logic [1:0] level_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic [1:0]  m_lvl, m_sent;
    int          m_seq, m_hb, m_pos;
    logic [39:0] m_frame;
    logic [1:0]  hist[$];

    alert_framer #(
        .NODE_ID   (NODE),
        .BIT_DIV   (BD),
        .STABLE_CNT(SC),
        .HEARTBEAT (HB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .alert_level(alert_level),
        .temp       (temp),
        .pres       (pres),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done),
        .level_q    (level_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 2'b00;
        m_sent = 2'b00;
        m_seq  = 0;
        m_hb   = 0;
        m_pos  = -1;
        m_frame = '0;
        hist.delete();
    endtask

    // One clock edge of the reference behaviour, using inputs present before the edge.
    task automatic model_step();
        bit all_eq;
`ifdef ALERT_FRAMER_CKSUM_EN
        logic [7:0] ck;
`endif
        if (m_pos < 0) begin
            if (enable && (m_lvl != m_sent || m_hb == HB - 1)) begin
`ifdef ALERT_FRAMER_CKSUM_EN
                ck = {NODE, m_lvl, m_seq[1:0]} ^ temp ^ pres;
                m_frame = {8'hA5, NODE, m_lvl, m_seq[1:0], temp, pres, ck};
`else
                m_frame = {8'h00, 8'hA5, NODE, m_lvl, m_seq[1:0], temp, pres};
`endif
                m_sent = m_lvl;
                m_seq  = (m_seq + 1) % 4;
                m_hb   = 0;
                m_pos  = 0;
            end else begin
                m_hb = enable ? m_hb + 1 : 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FL * BD + BD) m_pos = -1;
        end
        hist.push_back(alert_level);
        if (hist.size() > SC) void'(hist.pop_front());
        if (hist.size() == SC) begin
            all_eq = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
            if (all_eq) m_lvl = hist[0];
        end
    endtask

    task automatic check_outputs();
        logic exp_act, exp_bit, exp_done;
        exp_act  = (m_pos >= 0) && (m_pos < FL * BD);
        exp_bit  = exp_act ? m_frame[FL - 1 - m_pos / BD] : 1'b1;
        exp_done = (m_pos == FL * BD);
        check("tx_bit",     40'(tx_bit),     40'(exp_bit));
        check("tx_active",  40'(tx_active),  40'(exp_act));
        check("frame_done", 40'(frame_done), 40'(exp_done));
        check("level_q",    40'(level_q),    40'(m_lvl));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_tx_bit",     40'(tx_bit),     40'(1'b1));
        check("rst_tx_active",  40'(tx_active),  40'(1'b0));
        check("rst_frame_done", 40'(frame_done), 40'(1'b0));
        check("rst_level_q",    40'(level_q),    40'(2'b00));
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    // Waits for a frame, samples each bit once, and returns at the first GAP cycle.
    task automatic capture_frame(input bit do_mid, input logic [1:0] mid_alert,
                                 output logic [FL-1:0] cap, output int start);
        int k, act;
        cap = '0;
        k = 0;
        while (!tx_active && k < 400) begin
            tick();
            k++;
        end
        if (!tx_active) begin
            check("start_timeout", 40'(tx_active), 40'(1'b1));
            start = -1;
            return;
        end
        start = cyc;
        act = 1;
        cap[FL-1] = tx_bit;
        for (int i = 1; i < FL; i++) begin
            for (int j = 0; j < BD; j++) begin
                tick();
                if (tx_active) act++;
            end
            cap[FL-1-i] = tx_bit;
            if (do_mid && i == 3) alert_level = mid_alert;
        end
        for (int j = 0; j < BD; j++) begin
            tick();
            if (tx_active) act++;
        end
        check("frame_done_end", 40'(frame_done), 40'(1'b1));
        check("active_cycles",  40'(act),        40'(FL * BD));
    endtask

    logic [FL-1:0] cap;
    int            st, prev, hold;
    logic [7:0]    exp_ck;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // level glitch shorter than STABLE_CNT must not be accepted
        enable = 1'b1;
        alert_level = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        alert_level = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("glitch_level", 40'(level_q),   40'(2'b00));
            check("glitch_idle",  40'(tx_active), 40'(1'b0));
        end

        // level change frame: preamble, fields and start latency
        do_reset();
        enable = 1'b1;
        alert_level = 2'b10;
        temp = 8'h3C;
        pres = 8'h96;
        capture_frame(1'b0, 2'b00, cap, st);
        check("first_start", 40'(st), 40'(5));
        check("preamble",    40'(cap[XB+31:XB+24]), 40'(8'hA5));
        check("node_id",     40'(cap[XB+23:XB+20]), 40'(NODE));
        check("level_fld",   40'(cap[XB+19:XB+18]), 40'(2'b10));
        check("seq_fld",     40'(cap[XB+17:XB+16]), 40'(2'b00));
        check("temp_fld",    40'(cap[XB+15:XB+8]),  40'(8'h3C));
        check("pres_fld",    40'(cap[XB+7:XB+0]),   40'(8'h96));
        prev = st;

        // level changes during GAP: next frame on first IDLE cycle
        alert_level = 2'b11;
        capture_frame(1'b0, 2'b00, cap, st);
        check("gap_retrigger", 40'(st - prev), 40'(FL * BD + BD + 1));
        check("level_fld2",    40'(cap[XB+19:XB+18]), 40'(2'b11));
        check("seq_fld2",      40'(cap[XB+17:XB+16]), 40'(2'b01));
`ifdef ALERT_FRAMER_CKSUM_EN
        exp_ck = 8'h1D ^ 8'h3C ^ 8'h96;
        check("cksum_fld", 40'(cap[7:0]), 40'(exp_ck));
`else
        exp_ck = 8'h00;
`endif

        // heartbeat frames with a constant level
        do_reset();
        enable = 1'b1;
        alert_level = 2'b00;
        temp = 8'h5A;
        pres = 8'hC3;
        prev = 0;
        for (int f = 0; f < 5; f++) begin
            capture_frame(1'b0, 2'b00, cap, st);
            if (f == 0) check("hb_first", 40'(st), 40'(HB));
            else        check("hb_period", 40'(st - prev), 40'(HB + FL * BD + BD));
            check("hb_seq", 40'(cap[XB+17:XB+16]), 40'(f % 4));
            prev = st;
        end

        // level change mid-frame: frame unchanged, follow-up carries new level
        capture_frame(1'b1, 2'b01, cap, st);
        check("mid_period",  40'(st - prev), 40'(HB + FL * BD + BD));
        check("mid_level",   40'(cap[XB+19:XB+18]), 40'(2'b00));
        prev = st;
        capture_frame(1'b0, 2'b00, cap, st);
        check("follow_start", 40'(st - prev), 40'(FL * BD + BD + 1));
        check("follow_level", 40'(cap[XB+19:XB+18]), 40'(2'b01));

        // reset in the middle of a frame
        hold = 0;
        while (!tx_active && hold < 400) begin
            tick();
            hold++;
        end
        check("pre_rst_active", 40'(tx_active), 40'(1'b1));
        for (int i = 0; i < 10 * BD; i++) tick();
        check("pre_rst_level", 40'(level_q), 40'(2'b01));
        do_reset();
        for (int i = 0; i < 8; i++) tick();

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                alert_level = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 10);
            end
            hold--;
            enable = ($urandom_range(0, 15) != 0);
            temp   = 8'($urandom);
            pres   = 8'($urandom);
            if ($urandom_range(0, 799) == 0) do_reset();
            else                             tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
